csb2apb_bridge: RTL

- CSB-to-APB initiator bridge: accepts CSB requests from an NVDLA-side CSB master and replays each one as a single APB3 transfer to an external APB peripheral.
- Returns read data and non-posted write completions on the CSB response channel.
- Sits at the far end of a CSB link, in the opposite direction to the APB-to-CSB bridge.
- Handles one outstanding transaction at a time.

---
 rtl/csb2apb_pkg.sv | 21 ++
 rtl/csb2apb_timeout_cnt.sv | 36 +++
 rtl/csb2apb_bridge.sv | 138 +++++++++++++
 3 files changed

// File: rtl/csb2apb_pkg.sv
// Shared types and constants for the CSB-to-APB initiator bridge.
package csb2apb_pkg;

  localparam int CSB_ADDR_W = 16;
  localparam int DATA_W     = 32;

  localparam logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_e;

  // CSB carries word addresses; APB wants byte addresses in the 256 KiB window.
  function automatic logic [31:0] csb_to_paddr(input logic [31:0] base,
                                                input logic [CSB_ADDR_W-1:0] addr);
    return base | {14'b0, addr, 2'b00};
  endfunction

endpackage

// File: rtl/csb2apb_timeout_cnt.sv
// ACCESS-phase watchdog: clears on clr_i, counts enabled cycles, saturates at LIMIT-1.
// expire_o is combinational on the count so the abort lands in the terminal cycle.
module csb2apb_timeout_cnt #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  assign expire_o = (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && !expire_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/csb2apb_bridge.sv
// CSB request -> single APB3 transfer; response one cycle after completion (min 3 cycles), one outstanding.
// Request ready only in IDLE; responses are never backpressured. Optional watchdog: CSB2APB_TIMEOUT_EN.
module csb2apb_bridge
  import csb2apb_pkg::*;
#(
  parameter logic [31:0] APB_BASE       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  logic                  csb2nvdla_valid,
  output logic                  csb2nvdla_ready,
  input  logic [CSB_ADDR_W-1:0] csb2nvdla_addr,
  input  logic [DATA_W-1:0]     csb2nvdla_wdat,
  input  logic                  csb2nvdla_write,
  input  logic                  csb2nvdla_nposted,
  output logic                  nvdla2csb_valid,
  output logic [DATA_W-1:0]     nvdla2csb_data,
  output logic                  nvdla2csb_wr_complete,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [31:0]           paddr,
  output logic [DATA_W-1:0]     pwdata,
  input  logic [DATA_W-1:0]     prdata,
  input  logic                  pready,
  output logic                  apb_timeout
);

  state_e            state_q, state_d;
  logic              ready_q;
  logic [31:0]       paddr_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              nposted_q;
  logic              rsp_vld_q;
  logic              wr_cmp_q;
  logic [DATA_W-1:0] rdata_q;
  logic              accept;
  logic              done;
  logic              abort;

`ifdef CSB2APB_TIMEOUT_EN
  logic tmo_expire;
  logic tmo_q;

  csb2apb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i    (pclk),
    .rst_i    (prst),
    .clr_i    (state_q == SETUP),
    .en_i     ((state_q == ACCESS) && !pready),
    .expire_o (tmo_expire)
  );

  assign abort = (state_q == ACCESS) && !pready && tmo_expire;

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      tmo_q <= 1'b0;
    end else if (abort) begin
      tmo_q <= 1'b1;
    end
  end

  assign apb_timeout = tmo_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign abort              = 1'b0;
  assign apb_timeout        = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (csb2nvdla_valid && ready_q) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP:   state_d = ACCESS;
      ACCESS: begin
        if (pready || abort) begin
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ready is registered from the next state so it is low while held in reset
  // and already high in the response cycle for back-to-back accepts.
  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      state_q   <= IDLE;
      ready_q   <= 1'b0;
      paddr_q   <= '0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      nposted_q <= 1'b0;
      rsp_vld_q <= 1'b0;
      wr_cmp_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ready_q   <= (state_d == IDLE);
      if (accept) begin
        paddr_q   <= csb_to_paddr(APB_BASE, csb2nvdla_addr);
        pwrite_q  <= csb2nvdla_write;
        pwdata_q  <= csb2nvdla_wdat;
        nposted_q <= csb2nvdla_nposted;
      end
      rsp_vld_q <= done && !pwrite_q;
      wr_cmp_q  <= done && pwrite_q && nposted_q;
      if (done && !pwrite_q) begin
        rdata_q <= abort ? TIMEOUT_RDATA : prdata;
      end
    end
  end

  assign csb2nvdla_ready       = ready_q;
  assign psel                  = (state_q == SETUP) || (state_q == ACCESS);
  assign penable               = (state_q == ACCESS);
  assign pwrite                = pwrite_q;
  assign paddr                 = paddr_q;
  assign pwdata                = pwdata_q;
  assign nvdla2csb_valid       = rsp_vld_q;
  assign nvdla2csb_wr_complete = wr_cmp_q;
  assign nvdla2csb_data        = rdata_q;

endmodule
